// File: rtl/decrypter_in_param_pkg.sv
// Shared definitions for the receive-side decryption front end.
//   UART_W  : width of one UART byte
//   state_t : FSM state encoding used by decrypter_in_param
package decrypter_in_param_pkg;

  localparam int unsigned UART_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_HDR   = 3'd1;
  localparam state_t S_DATA  = 3'd2;
  localparam state_t S_ISSUE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/decrypter_in_param_if.sv
// UART-receive and FME-issue handshake bundle.
//   ready_in/data_in/clear_rx_flag : UART byte flag, byte, and acknowledge
//   fme_busy/fme_start/fme_data_in : FME back-pressure, start pulse, word
// master : the decrypter front end
// slave  : the UART receiver / FME side
interface decrypter_in_param_if #(
  parameter int unsigned WORD_W = 32
);
  logic              ready_in;
  logic [7:0]        data_in;
  logic              clear_rx_flag;
  logic              fme_busy;
  logic              fme_start;
  logic [WORD_W-1:0] fme_data_in;

  modport master (
    input  ready_in, data_in, fme_busy,
    output clear_rx_flag, fme_start, fme_data_in
  );

  modport slave (
    output ready_in, data_in, fme_busy,
    input  clear_rx_flag, fme_start, fme_data_in
  );
endinterface

// File: rtl/decrypter_in_param_byte_packer.sv
// Parameterised byte-to-word shift register with byte counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the partial word and counter
//   shift      : accept data_in this cycle
//   data_in    : incoming byte
//   word_full  : this accepted byte completes a word
//   word       : assembled word including the current byte
module decrypter_in_param_byte_packer
  import decrypter_in_param_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic [UART_W-1:0] data_in,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned BYTES = WORD_W / UART_W;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0] byte_cnt;

  assign word_full = shift && (byte_cnt == CNT_W'(BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (shift) begin
      byte_cnt <= word_full ? '0 : byte_cnt + CNT_W'(1);
    end
  end

  // Only the WORD_W-8 bits that survive into the next word are stored;
  // the newest byte is spliced in combinationally to form the word.
  generate
    if (WORD_W == UART_W) begin : g_single
      assign word = data_in;
    end else begin : g_multi
      logic [WORD_W-UART_W-1:0] pack;

      if (MSB_FIRST) begin : g_msb
        assign word = {pack, data_in};
      end else begin : g_lsb
        assign word = {data_in, pack};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pack <= '0;
        end else if (clr) begin
          pack <= '0;
        end else if (shift) begin
          if (MSB_FIRST) pack <= word[WORD_W-UART_W-1:0];
          else           pack <= word[WORD_W-1:UART_W];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decrypter_in_param.sv
// Receive-side front end of the decryption path: packs UART bytes into
// WORD_W-bit words, reads a length header, then issues each ciphertext
// word to the FME with a one-cycle fme_start.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a message (sampled in IDLE only)
//   abort      : return to IDLE from any state, highest priority
//   bus        : UART byte handshake and FME issue handshake
//   busy       : high outside IDLE
//   done       : one-cycle pulse after the last word is issued
//   err_len    : one-cycle pulse when the header length is zero
//   word_count : words issued in the current message
module decrypter_in_param
  import decrypter_in_param_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned LEN_W     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  decrypter_in_param_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len,
  output logic [LEN_W-1:0]     word_count
);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [WORD_W-1:0] fme_data_q;
  logic              accept;
  logic              word_full;
  logic [WORD_W-1:0] word;
  logic              issue;
  logic [LEN_W:0]    wc_inc;
  logic              last_word;
  logic              len_zero;

  assign accept = ((state == S_HDR) || (state == S_DATA)) && bus.ready_in && !abort;

  decrypter_in_param_byte_packer #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state == S_IDLE),
    .shift     (accept),
    .data_in   (bus.data_in),
    .word_full (word_full),
    .word      (word)
  );

  assign issue = (state == S_ISSUE) && !bus.fme_busy && !abort;

  // Carry bit keeps the last-word test exact when len is all ones.
  assign wc_inc    = {1'b0, word_count} + (LEN_W + 1)'(1);
  assign last_word = (wc_inc == {1'b0, len_q});
  assign len_zero  = (word[LEN_W-1:0] == '0);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start)          state_nxt = S_HDR;
        S_HDR:   if (word_full)      state_nxt = len_zero ? S_IDLE : S_DATA;
        S_DATA:  if (word_full)      state_nxt = S_ISSUE;
        S_ISSUE: if (!bus.fme_busy)  state_nxt = last_word ? S_DONE : S_DATA;
        S_DONE:                      state_nxt = S_IDLE;
        default:                     state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      word_count <= '0;
      fme_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        len_q      <= '0;
        word_count <= '0;
      end else begin
        if ((state == S_HDR) && word_full)  len_q      <= word[LEN_W-1:0];
        if ((state == S_DATA) && word_full) fme_data_q <= word;
        if (issue)                          word_count <= wc_inc[LEN_W-1:0];
      end
    end
  end

  // IDLE acknowledges unconditionally so stale UART bytes are flushed;
  // ISSUE never acknowledges so the next byte stays pending in the UART.
  assign bus.clear_rx_flag = (state == S_IDLE) || accept;
  assign bus.fme_start     = issue;
  assign bus.fme_data_in   = fme_data_q;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE) && !abort;
  assign err_len = (state == S_HDR) && word_full && len_zero;

endmodule

// File: tb/tb_decrypter_in_param.sv
module tb_decrypter_in_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // index 0: 32-bit MSB-first, 1: 32-bit LSB-first, 2: 64-bit MSB-first
  logic        start_v[3];
  logic        abort_v[3];
  logic        ready_v[3];
  logic        busy_v[3];
  logic [7:0]  data_v[3];
  logic        clr_v[3];
  logic        fs_v[3];
  logic        bsy_v[3];
  logic        done_v[3];
  logic        err_v[3];
  logic [63:0] fd_v[3];
  logic [31:0] wc_v[3];

  decrypter_in_param_if #(.WORD_W(32)) bus0 ();
  decrypter_in_param_if #(.WORD_W(32)) bus1 ();
  decrypter_in_param_if #(.WORD_W(64)) bus2 ();

  assign bus0.ready_in = ready_v[0];
  assign bus0.data_in  = data_v[0];
  assign bus0.fme_busy = busy_v[0];
  assign bus1.ready_in = ready_v[1];
  assign bus1.data_in  = data_v[1];
  assign bus1.fme_busy = busy_v[1];
  assign bus2.ready_in = ready_v[2];
  assign bus2.data_in  = data_v[2];
  assign bus2.fme_busy = busy_v[2];

  assign clr_v[0] = bus0.clear_rx_flag;
  assign clr_v[1] = bus1.clear_rx_flag;
  assign clr_v[2] = bus2.clear_rx_flag;
  assign fs_v[0]  = bus0.fme_start;
  assign fs_v[1]  = bus1.fme_start;
  assign fs_v[2]  = bus2.fme_start;
  assign fd_v[0]  = 64'(bus0.fme_data_in);
  assign fd_v[1]  = 64'(bus1.fme_data_in);
  assign fd_v[2]  = bus2.fme_data_in;

  decrypter_in_param #(.WORD_W(32), .LEN_W(32), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .bus(bus0),
    .busy(bsy_v[0]), .done(done_v[0]), .err_len(err_v[0]), .word_count(wc_v[0]));

  decrypter_in_param #(.WORD_W(32), .LEN_W(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .bus(bus1),
    .busy(bsy_v[1]), .done(done_v[1]), .err_len(err_v[1]), .word_count(wc_v[1]));

  decrypter_in_param #(.WORD_W(64), .LEN_W(32), .MSB_FIRST(1'b1)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .bus(bus2),
    .busy(bsy_v[2]), .done(done_v[2]), .err_len(err_v[2]), .word_count(wc_v[2]));

  // Observation of pulse outputs, sampled on the falling edge.
  logic [63:0] got_q[3][$];
  int unsigned fs_cyc[3]   = '{0, 0, 0};
  int unsigned done_cyc[3] = '{0, 0, 0};
  int          done_n[3]   = '{0, 0, 0};
  int          err_n[3]    = '{0, 0, 0};
  int          excl_bad[3] = '{0, 0, 0};
  logic [31:0] done_wc[3];
  int unsigned acc_cyc = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (fs_v[d] === 1'b1) begin got_q[d].push_back(fd_v[d]); fs_cyc[d] = cyc; end
      if (done_v[d] === 1'b1) begin done_n[d]++; done_cyc[d] = cyc; done_wc[d] = wc_v[d]; end
      if (err_v[d] === 1'b1) err_n[d]++;
      if (int'(fs_v[d]) + int'(done_v[d]) + int'(err_v[d]) > 1) excl_bad[d]++;
    end
  end

  // Reference: word k of a message is built from its bytes by weight.
  function automatic logic [63:0] pack_word(input logic [7:0] q[$], input int unsigned base,
                                            input int unsigned nb, input bit msb);
    logic [63:0] w = '0;
    for (int unsigned i = 0; i < nb; i++) begin
      if (msb) w = (w << 8) | 64'(q[base+i]);
      else     w = w | (64'(q[base+i]) << (8 * i));
    end
    return w;
  endfunction

  // All stimulus helpers are entered and left at posedge+1.
  task automatic start_msg(input int d);
    @(posedge clk); #1; start_v[d] = 1'b1;
    @(posedge clk); #1; start_v[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit rnd);
    bit ok = 1'b0;
    data_v[d]  = b;
    ready_v[d] = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (rnd) busy_v[d] = ($urandom_range(0, 2) == 0);
      #1;
      if (clr_v[d] === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
    end else begin
      vectors++; miscompares++;
      $display("FAIL byte_accept_timeout dut%0d: clear_rx_flag got 0, expected 1", d);
    end
    ready_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input bit rnd);
    bit ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge clk); #1;
      if (rnd) busy_v[d] = ($urandom_range(0, 2) == 0);
      #1;
      if (bsy_v[d] === 1'b0) ok = 1'b1;
    end
    busy_v[d] = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout dut%0d: busy got 1, expected 0", d);
    end
  endtask

  task automatic run_msg(input int d, input logic [7:0] q[$], input bit rnd);
    start_msg(d);
    foreach (q[i]) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(d, q[i], rnd);
    end
    wait_idle(d, rnd);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({bsy_v[d], fs_v[d], done_v[d], err_v[d]} !== 4'b0) begin
        miscompares++;
        $display("FAIL reset_flags dut%0d: got %b, expected 0000", d, {bsy_v[d], fs_v[d], done_v[d], err_v[d]});
      end
      vectors++;
      if (fd_v[d] !== 64'h0) begin miscompares++; $display("FAIL reset_data dut%0d: got %h, expected 0", d, fd_v[d]); end
      vectors++;
      if (wc_v[d] !== 32'h0) begin miscompares++; $display("FAIL reset_count dut%0d: got %0d, expected 0", d, wc_v[d]); end
      vectors++;
      if (clr_v[d] !== 1'b1) begin miscompares++; $display("FAIL reset_clear dut%0d: got %b, expected 1", d, clr_v[d]); end
    end
  endtask

  task automatic test_basic(input int d, input bit msb);
    logic [7:0] q[$];
    int dn = done_n[d];
    if (msb) q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    else     q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    got_q[d].delete();
    run_msg(d, q, 1'b0);
    vectors++;
    if (got_q[d].size() != 2) begin
      miscompares++; $display("FAIL basic_count dut%0d: got %0d words, expected 2", d, got_q[d].size());
    end
    for (int k = 0; k < 2 && k < got_q[d].size(); k++) begin
      vectors++;
      if (got_q[d][k] !== pack_word(q, 4 * (k + 1), 4, msb)) begin
        miscompares++;
        $display("FAIL basic_word%0d dut%0d: got %h, expected %h", k, d, got_q[d][k], pack_word(q, 4 * (k + 1), 4, msb));
      end
    end
    vectors++;
    if (done_n[d] - dn != 1) begin miscompares++; $display("FAIL basic_done dut%0d: got %0d pulses, expected 1", d, done_n[d] - dn); end
    vectors++;
    if (done_wc[d] !== 32'd2) begin miscompares++; $display("FAIL basic_wc dut%0d: got %0d, expected 2", d, done_wc[d]); end
    vectors++;
    if (done_cyc[d] != fs_cyc[d] + 1) begin
      miscompares++; $display("FAIL basic_done_timing dut%0d: got cycle %0d, expected %0d", d, done_cyc[d], fs_cyc[d] + 1);
    end
  endtask

  task automatic test_err_len();
    logic [7:0] q[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int en = err_n[0];
    int dn = done_n[0];
    got_q[0].delete();
    run_msg(0, q, 1'b0);
    vectors++;
    if (err_n[0] - en != 1) begin miscompares++; $display("FAIL err_pulse: got %0d pulses, expected 1", err_n[0] - en); end
    vectors++;
    if (got_q[0].size() != 0 || done_n[0] != dn) begin
      miscompares++; $display("FAIL err_no_issue: got %0d starts %0d dones, expected 0 0", got_q[0].size(), done_n[0] - dn);
    end
  endtask

  task automatic test_busy_stall();
    logic [7:0] q[$] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hC0, 8'hFF, 8'hEE, 8'h01,
                         8'h55, 8'h66, 8'h77, 8'h88};
    int unsigned a;
    int dn = done_n[0];
    got_q[0].delete();
    busy_v[0] = 1'b1;
    start_msg(0);
    for (int i = 0; i < 8; i++) send_byte(0, q[i], 1'b0);
    a = acc_cyc;
    data_v[0]  = q[8];
    ready_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if ({fs_v[0], clr_v[0]} !== 2'b00) begin
        miscompares++; $display("FAIL stall_hold%0d: start,clear got %b, expected 00", k, {fs_v[0], clr_v[0]});
      end
      @(posedge clk); #1;
    end
    busy_v[0] = 1'b0;
    #1;
    vectors++;
    if ({fs_v[0], clr_v[0]} !== 2'b10) begin
      miscompares++; $display("FAIL stall_release: start,clear got %b, expected 10", {fs_v[0], clr_v[0]});
    end
    vectors++;
    if (cyc - a != 5) begin miscompares++; $display("FAIL stall_delay: got %0d cycles, expected 5", cyc - a); end
    vectors++;
    if (fd_v[0] !== pack_word(q, 4, 4, 1'b1)) begin
      miscompares++; $display("FAIL stall_data: got %h, expected %h", fd_v[0], pack_word(q, 4, 4, 1'b1));
    end
    @(posedge clk); #2;
    vectors++;
    if (clr_v[0] !== 1'b1) begin miscompares++; $display("FAIL stall_resume_ack: got %b, expected 1", clr_v[0]); end
    @(posedge clk); #1;
    ready_v[0] = 1'b0;
    for (int i = 9; i < 12; i++) send_byte(0, q[i], 1'b0);
    wait_idle(0, 1'b0);
    vectors++;
    if (got_q[0].size() != 2 || got_q[0][1] !== pack_word(q, 8, 4, 1'b1)) begin
      miscompares++; $display("FAIL stall_second_word: got %0d words, expected 2 ending %h", got_q[0].size(), pack_word(q, 8, 4, 1'b1));
    end
    vectors++;
    if (done_n[0] - dn != 1) begin miscompares++; $display("FAIL stall_done: got %0d, expected 1", done_n[0] - dn); end
  endtask

  task automatic test_abort();
    logic [7:0] hq[$] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD};
    logic [7:0] q[$]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [63:0] prev;
    start_msg(0);
    foreach (hq[i]) send_byte(0, hq[i], 1'b0);
    prev       = fd_v[0];
    abort_v[0] = 1'b1;
    data_v[0]  = 8'hBE;
    ready_v[0] = 1'b1;
    #1;
    vectors++;
    if ({fs_v[0], done_v[0], err_v[0], clr_v[0]} !== 4'b0) begin
      miscompares++; $display("FAIL abort_quiet: start,done,err,clear got %b, expected 0000", {fs_v[0], done_v[0], err_v[0], clr_v[0]});
    end
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    ready_v[0] = 1'b0;
    #1;
    vectors++;
    if (bsy_v[0] !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy got %b, expected 0", bsy_v[0]); end
    vectors++;
    if (fd_v[0] !== prev) begin miscompares++; $display("FAIL abort_data_kept: got %h, expected %h", fd_v[0], prev); end
    got_q[0].delete();
    run_msg(0, q, 1'b0);
    vectors++;
    if (got_q[0].size() != 1 || got_q[0][0] !== 64'h01020304) begin
      miscompares++; $display("FAIL abort_fresh_msg: got %0d words, expected 1 word 01020304", got_q[0].size());
    end
    vectors++;
    if (done_wc[0] !== 32'd1) begin miscompares++; $display("FAIL abort_fresh_wc: got %0d, expected 1", done_wc[0]); end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 6; m++) begin
        logic [7:0] q[$];
        int unsigned len = $urandom_range(1, 4);
        int dn = done_n[d];
        bit msb = (d == 0);
        for (int i = 0; i < 4; i++) q.push_back(((msb && i == 3) || (!msb && i == 0)) ? 8'(len) : 8'h00);
        for (int unsigned i = 0; i < 4 * len; i++) q.push_back(8'($urandom_range(0, 255)));
        got_q[d].delete();
        run_msg(d, q, 1'b1);
        vectors++;
        if (got_q[d].size() != len) begin
          miscompares++; $display("FAIL rand_count dut%0d msg%0d: got %0d, expected %0d", d, m, got_q[d].size(), len);
        end
        for (int unsigned k = 0; k < len && k < got_q[d].size(); k++) begin
          vectors++;
          if (got_q[d][k] !== pack_word(q, 4 * (k + 1), 4, msb)) begin
            miscompares++;
            $display("FAIL rand_word dut%0d msg%0d w%0d: got %h, expected %h", d, m, k, got_q[d][k], pack_word(q, 4 * (k + 1), 4, msb));
          end
        end
        vectors++;
        if (done_n[d] - dn != 1 || done_wc[d] != len) begin
          miscompares++; $display("FAIL rand_done dut%0d msg%0d: got %0d pulses wc %0d, expected 1 wc %0d", d, m, done_n[d] - dn, done_wc[d], len);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] q[$] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                         8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    int dn = done_n[2];
    got_q[2].delete();
    run_msg(2, q, 1'b0);
    vectors++;
    if (got_q[2].size() != 1 || got_q[2][0] !== 64'h0102030405060708) begin
      miscompares++; $display("FAIL wide_word: got %0d words, expected 1 word 0102030405060708", got_q[2].size());
    end
    vectors++;
    if (done_n[2] - dn != 1 || done_wc[2] !== 32'd1) begin
      miscompares++; $display("FAIL wide_done: got %0d pulses wc %0d, expected 1 wc 1", done_n[2] - dn, done_wc[2]);
    end
  endtask

  task automatic test_async_reset();
    start_msg(2);
    for (int i = 0; i < 3; i++) send_byte(2, 8'hA0 + 8'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bsy_v[2], fs_v[2], done_v[2], err_v[2]} !== 4'b0 || wc_v[2] !== 32'h0) begin
      miscompares++; $display("FAIL async_reset_flags: got %b wc %0d, expected 0000 wc 0", {bsy_v[2], fs_v[2], done_v[2], err_v[2]}, wc_v[2]);
    end
    vectors++;
    if (fd_v[2] !== 64'h0 || fd_v[0] !== 64'h0) begin
      miscompares++; $display("FAIL async_reset_data: got %h / %h, expected 0", fd_v[2], fd_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0; abort_v[d] = 1'b0; ready_v[d] = 1'b0;
      busy_v[d]  = 1'b0; data_v[d]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic(0, 1'b1);
    test_basic(1, 1'b0);
    test_err_len();
    test_busy_stall();
    test_abort();
    test_random();
    test_wide();
    test_async_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (excl_bad[d] != 0) begin
        miscompares++; $display("FAIL pulse_exclusive dut%0d: got %0d overlapping cycles, expected 0", d, excl_bad[d]);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decrypter_in_param.md
Name: decrypter_in_param

Overview:
Receive-side front end of the decryption path.
- Consumes bytes from the UART receiver (ready_in/data_in with clear_rx_flag acknowledge).
- Packs the bytes into WORD_W-bit words and hands each ciphertext word to the modular-exponentiation engine (FME) with a one-cycle fme_start pulse.
- The first word of a message is a length header giving the number of ciphertext words that follow.
- Generalises the 32-bit packer with these additions:
  - configurable word width and byte order;
  - FME back-pressure (fme_busy);
  - abort;
  - explicit done and error reporting.

Parameters:
- WORD_W, 32: ciphertext word width in bits. Must be a multiple of 8, range 8..256.
- LEN_W, 32: width of the length field, taken from the low LEN_W bits of the header word. Must satisfy LEN_W <= WORD_W.
- MSB_FIRST, 1: byte order. 1 = the first received byte lands in the most significant byte; 0 = the first received byte lands in the least significant byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin receiving a message. Sampled in IDLE only.
- abort  in  1  return to IDLE from any state.
- ready_in  in  1  UART byte-available flag.
- data_in  in  8  UART received byte.
- clear_rx_flag  out  1  acknowledge/clear of the UART flag.
- fme_busy  in  1  FME cannot accept a new word.
- fme_start  out  1  one-cycle pulse; fme_data_in is valid in the same cycle.
- fme_data_in  out  WORD_W  packed ciphertext word (registered).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is issued.
- err_len  out  1  one-cycle pulse when the header length is 0.
- word_count  out  LEN_W  number of words issued in the current message.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE. All registers, fme_data_in and word_count are cleared to 0. All pulse outputs are 0.
- localparam BYTES = WORD_W/8. byte_cnt has width $clog2(BYTES), minimum 1 bit.
- Shift rule on each accepted byte:
  - MSB_FIRST=1: pack <= {pack[WORD_W-9:0], data_in}
  - MSB_FIRST=0: pack <= {data_in, pack[WORD_W-1:8]}
- IDLE:
  - clear_rx_flag = 1 every cycle, which flushes any stale byte.
  - pack, byte_cnt, len and word_count are held at 0.
  - start -> HDR.
- HDR:
  - On ready_in: clear_rx_flag = 1 in the same cycle, shift the byte in, byte_cnt++.
  - On the BYTES-th byte, compute len = assembled word[LEN_W-1:0], where the assembled word includes the current byte.
  - len == 0: err_len pulse, -> IDLE.
  - Otherwise: byte_cnt wraps to 0, -> DATA.
- DATA:
  - Same byte acceptance as HDR.
  - On the BYTES-th byte, fme_data_in <= assembled word, -> ISSUE.
- ISSUE:
  - clear_rx_flag = 0, so incoming bytes stay pending in the UART and are not consumed.
  - If fme_busy = 0: fme_start = 1 and word_count++.
    - If word_count+1 == len -> DONE; else -> DATA.
  - If fme_busy = 1: hold in ISSUE with fme_data_in stable.
- DONE: done = 1 for one cycle, -> IDLE.
- Latency: the accepted last byte of a word at edge N produces fme_start at N+1 at the earliest (fme_busy low). Each extra cycle of fme_busy adds one cycle.
- Only one byte is accepted per cycle. A ready_in that stays high across the acknowledge cycle is the UART's responsibility to drop one cycle after clear_rx_flag.
- abort has priority over every other condition:
  - next state = IDLE;
  - no fme_start, done or err_len in that cycle;
  - fme_data_in keeps its last value.
- start while not in IDLE is ignored.
- len = 2^LEN_W-1: word_count must not overflow before DONE. The comparison uses the LEN_W-bit word_count+1 computed with a carry bit.
- fme_start, done and err_len are mutually exclusive in any cycle.

Decomposition:
- The shared crypt package holds:
  - the state encoding (IDLE, HDR, DATA, ISSUE, DONE) as a typedef;
  - the UART byte width constant (8).
- One sub-module is natural: byte_packer, holding the parameterised shift register and byte counter, with outputs word_full and word.
- The FSM, length register and word counter live in the top level.

Test Plan:
- WORD_W=32, MSB_FIRST=1: header bytes 00 00 00 02, then data 11 22 33 44 and AA BB CC DD, fme_busy=0 -> two fme_start pulses with fme_data_in = 0x11223344 then 0xAABBCCDD. done pulses one cycle after the second fme_start; word_count=2.
- MSB_FIRST=0, same byte stream -> header len = 0x02000000 truncated to LEN_W=32. Use header 02 00 00 00 instead, giving len=2; first word = 0x44332211.
- Header 00 00 00 00 -> err_len single pulse, back to IDLE, no fme_start.
- fme_busy held high 5 cycles after the first word completes -> fme_start delayed exactly 5 cycles. clear_rx_flag stays low meanwhile and the next byte is accepted only after issue.
- abort asserted after 2 data bytes -> IDLE next cycle, busy=0. A new start with a fresh message packs correctly, with no residue from the aborted bytes.
- WORD_W=64, len=1, bytes 01..08 -> one fme_start with 0x0102030405060708, then done. Also assert rst_n low mid-word -> all outputs 0 immediately, with no clock edge required.
